// File: rtl/trng_pkg.sv
// Shared types and constants for the TRNG debias/packing path.
package trng_pkg;

    typedef enum logic [1:0] {
        PAIR_A = 2'd0,
        PAIR_B = 2'd1,
        FULL   = 2'd2
    } state_t;

    // Raw pair {first, second} patterns that yield a debiased bit.
    localparam logic [1:0] VN_01 = 2'b01;
    localparam logic [1:0] VN_10 = 2'b10;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_RCT_LIMIT = 32;

endpackage

// File: rtl/rct_monitor.sv
// Repetition-count health test: counts consecutive identical raw bits and
// raises a sticky failure once the run reaches LIMIT.
module rct_monitor #(
    parameter int LIMIT = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_valid,
    input  logic raw_bit,
    output logic health_fail
);

    localparam int RUN_W = $clog2(LIMIT + 1);

    logic [RUN_W-1:0] run_q, run_d;
    logic             prev_q, prev_d;
    logic             fail_q, fail_d;

    always_comb begin
        run_d  = run_q;
        prev_d = prev_q;
        if (sample_valid) begin
            prev_d = raw_bit;
            // A zero count means no sample seen yet, so the first one starts a run.
            if (run_q != '0 && raw_bit == prev_q) begin
                run_d = (run_q == RUN_W'(LIMIT)) ? run_q : run_q + 1'b1;
            end else begin
                run_d = RUN_W'(1);
            end
        end
        fail_d = fail_q | (run_d == RUN_W'(LIMIT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q  <= '0;
            prev_q <= 1'b0;
            fail_q <= 1'b0;
        end else begin
            run_q  <= run_d;
            prev_q <= prev_d;
            fail_q <= fail_d;
        end
    end

    assign health_fail = fail_q;

endmodule

// File: rtl/vn_debias_packer.sv
// Von Neumann debiaser and word packer feeding the TRNG data register.
// Optional repetition-count health test enabled by TRNG_HEALTH_EN.
module vn_debias_packer
    import trng_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DROP_CNT_W = 8,
    parameter int RCT_LIMIT  = DEF_RCT_LIMIT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_valid,
    input  logic                  raw_bit,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    output logic                  health_fail,
    output state_t                dbg_state
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      data_q, data_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  first_q, first_d;
    logic                  valid_q, valid_d;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;
    logic                  health_fail_w;
    logic [1:0]            pair;
    logic                  accept;

`ifdef TRNG_HEALTH_EN
    rct_monitor #(.LIMIT(RCT_LIMIT)) u_rct (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .raw_bit      (raw_bit),
        .health_fail  (health_fail_w)
    );
`else
    logic unused_rct;
    assign unused_rct    = RCT_LIMIT[0];
    assign health_fail_w = 1'b0;
`endif

    assign pair   = {first_q, raw_bit};
    // A failed health test blocks acceptance so no further word can complete.
    assign accept = ((pair == VN_01) || (pair == VN_10)) && !health_fail_w;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        valid_d = valid_q;
        drop_d  = drop_q;
        case (state_q)
            PAIR_A: begin
                if (sample_valid) begin
                    first_d = raw_bit;
                    state_d = PAIR_B;
                end
            end
            PAIR_B: begin
                if (sample_valid) begin
                    state_d = PAIR_A;
                    if (accept) begin
                        data_d = {data_q[WIDTH-2:0], first_q};
                        if (cnt_q == CNT_W'(WIDTH - 1)) begin
                            cnt_d   = '0;
                            state_d = FULL;
                            valid_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            end
            FULL: begin
                if (sample_valid && drop_q != '1) begin
                    drop_d = drop_q + 1'b1;
                end
                if (out_valid && out_ready) begin
                    state_d = PAIR_A;
                    valid_d = 1'b0;
                end
            end
            default: state_d = PAIR_A;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PAIR_A;
            data_q  <= '0;
            cnt_q   <= '0;
            first_q <= 1'b0;
            valid_q <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
        end
    end

    assign out_valid   = valid_q & ~health_fail_w;
    assign out_data    = data_q;
    assign drop_cnt    = drop_q;
    assign health_fail = health_fail_w;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_vn_debias_packer.sv
// Directed bench for vn_debias_packer; build with or without TRNG_HEALTH_EN.
module tb_vn_debias_packer;
    import trng_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       sample_valid;
    logic       raw_bit;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [7:0] drop_cnt;
    logic       health_fail;
    state_t     dbg_state;

    int n_vec = 0;
    int n_err = 0;

    vn_debias_packer #(.WIDTH(8), .DROP_CNT_W(8), .RCT_LIMIT(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .raw_bit      (raw_bit),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .drop_cnt     (drop_cnt),
        .health_fail  (health_fail),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Each driver step starts and ends at a falling edge, so checks land mid-cycle.
    task automatic sample(input logic b);
        @(negedge clk);
        sample_valid = 1'b1;
        raw_bit      = b;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic pair(input logic a, input logic b);
        sample(a);
        sample(b);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic handshake(input logic with_sample, input logic b);
        @(negedge clk);
        out_ready    = 1'b1;
        sample_valid = with_sample;
        raw_bit      = b;
        @(negedge clk);
        out_ready    = 1'b0;
        sample_valid = 1'b0;
    endtask

    logic exp_hf;
    logic exp_v6;

    initial begin
`ifdef TRNG_HEALTH_EN
        exp_hf = 1'b1;
        exp_v6 = 1'b0;
`else
        exp_hf = 1'b0;
        exp_v6 = 1'b1;
`endif
        rst = 1'b1; sample_valid = 1'b0; raw_bit = 1'b0; out_ready = 1'b0;
        idle(2);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'h00);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_health", 32'(health_fail), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(PAIR_A));
        rst = 1'b0;

        // Word 1: pairs 10,01,10,10,01,01,10,01 -> 1011_0010.
        sample(1'b1);
        chk("w1_state_b", 32'(dbg_state), 32'(PAIR_B));
        sample(1'b0);
        pair(0, 1); pair(1, 0); pair(1, 0); pair(0, 1); pair(0, 1); pair(1, 0);
        chk("w1_not_yet", 32'(out_valid), 32'd0);
        pair(0, 1);
        chk("w1_valid", 32'(out_valid), 32'd1);
        chk("w1_data", 32'(out_data), 32'hB2);
        chk("w1_state_full", 32'(dbg_state), 32'(FULL));

        // Backpressure: five drops, data stable, then drop on the handshake cycle.
        for (int i = 0; i < 5; i++) sample(i[0]);
        chk("bp_data", 32'(out_data), 32'hB2);
        chk("bp_drop5", 32'(drop_cnt), 32'd5);
        chk("bp_valid", 32'(out_valid), 32'd1);
        handshake(1'b1, 1'b1);
        chk("hs_valid", 32'(out_valid), 32'd0);
        chk("hs_drop6", 32'(drop_cnt), 32'd6);
        chk("hs_state", 32'(dbg_state), 32'(PAIR_A));
        chk("hs_data_kept", 32'(out_data), 32'hB2);

        // Discarded pairs with idle gaps: only the final 10 contributes one bit.
        pair(0, 0); idle(3); pair(1, 1); idle(2); pair(0, 0); idle(1); pair(1, 0); idle(4);
        chk("disc_valid", 32'(out_valid), 32'd0);
        chk("disc_data", 32'(out_data), 32'h65);
        for (int i = 0; i < 6; i++) pair(0, 1);
        chk("disc_count_7", 32'(out_valid), 32'd0);
        pair(0, 1);
        chk("disc_count_8", 32'(out_valid), 32'd1);
        chk("disc_word", 32'(out_data), 32'h80);
        handshake(1'b0, 1'b0);
        chk("hs2_valid", 32'(out_valid), 32'd0);
        chk("hs2_drop", 32'(drop_cnt), 32'd6);

        // Saturation of the drop counter.
        for (int i = 0; i < 8; i++) pair(1, 0);
        chk("sat_word", 32'(out_data), 32'hFF);
        for (int i = 0; i < 248; i++) sample(i[0]);
        chk("sat_254", 32'(drop_cnt), 32'd254);
        sample(1'b0);
        chk("sat_255", 32'(drop_cnt), 32'd255);
        for (int i = 0; i < 51; i++) sample(i[0]);
        chk("sat_hold", 32'(drop_cnt), 32'd255);
        chk("sat_valid", 32'(out_valid), 32'd1);
        handshake(1'b0, 1'b0);
        chk("hs3_valid", 32'(out_valid), 32'd0);

        // Reset mid-word: three bits accepted, then lost.
        pair(1, 0); pair(1, 0); pair(1, 0);
        @(negedge clk);
        rst = 1'b1;
        #2;
        chk("mid_rst_data", 32'(out_data), 32'h00);
        chk("mid_rst_drop", 32'(drop_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pair(0, 1); pair(1, 0); pair(0, 1); pair(0, 1); pair(1, 0); pair(1, 0); pair(0, 1);
        chk("post_rst_7", 32'(out_valid), 32'd0);
        pair(1, 0);
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_word", 32'(out_data), 32'h4D);
        handshake(1'b0, 1'b0);

        // Repetition run of 32 ones.
        for (int i = 0; i < 31; i++) sample(1'b1);
        chk("rct_31", 32'(health_fail), 32'd0);
        sample(1'b1);
        chk("rct_32", 32'(health_fail), 32'(exp_hf));
        idle(2);
        chk("rct_sticky", 32'(health_fail), 32'(exp_hf));
        for (int i = 0; i < 8; i++) pair(1, 0);
        chk("rct_valid", 32'(out_valid), 32'(exp_v6));
        chk("rct_health_end", 32'(health_fail), 32'(exp_hf));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vn_debias_packer.md
Name: vn_debias_packer

Overview:
- Upstream stage of the TRNG output data register; sits between the sampled ring-oscillator noise bit and the WIDTH-bit data register.
- Applies von Neumann debiasing to non-overlapping raw-bit pairs and packs the accepted bits into a WIDTH-bit word.
- Presents the word on a valid/ready handshake; out_valid & out_ready drives the data register's en.

Parameters:
- WIDTH, 8, output word width and number of debiased bits per word (>=2).
- DROP_CNT_W, 8, width of the saturating dropped-sample counter.
- RCT_LIMIT, 32, repetition-count health-test threshold (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- sample_valid  in  1  raw_bit is a fresh noise sample this cycle.
- raw_bit  in  1  sampled noise bit.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_valid  out  1  out_data holds a complete word.
- out_data  out  WIDTH  packed debiased word.
- drop_cnt  out  DROP_CNT_W  samples discarded while a word was pending; saturating.
- health_fail  out  1  sticky repetition-count failure (see Optional Feature).

Behaviour:
- Reset (async, rst=1): state=PAIR_A, out_valid=0, out_data=0, bit count=0, drop_cnt=0, health_fail=0, first-bit latch=0.
- States:
  - PAIR_A: waiting for the first bit of a pair. On sample_valid, latch raw_bit and go to PAIR_B.
  - PAIR_B: waiting for the second bit. On sample_valid, go to PAIR_A and decode the pair:
    - 01 yields 0; 10 yields 1 (accepted bit = first bit).
    - 00 or 11: discard; shift register and count unchanged.
  - FULL: word pending. out_valid=1.
- Packing:
  - Each accepted bit is shifted into out_data bit 0 (shift left), so the earliest accepted bit ends at the MSB.
  - The count increments per accepted bit. When the WIDTH-th bit is accepted, the next state is FULL and the count clears.
  - out_valid rises the cycle after the completing sample (1-cycle latency).
- Handshake in FULL:
  - out_data is stable while out_valid=1.
  - When out_valid & out_ready, the next state is PAIR_A and out_valid=0 the following cycle.
  - out_data keeps its last value; it is overwritten bit by bit by the next word.
- Drops:
  - A sample_valid in FULL is discarded and increments drop_cnt, including in the handshake-completion cycle.
  - drop_cnt holds at all-ones once saturated; it is cleared only by rst.
- Pair alignment: always restarts at PAIR_A after FULL, so no partial pair spans a word boundary.
- Idle: when sample_valid=0, state and data are unchanged in every state.
- Reset mid-word or mid-handshake: partial bits are lost, and out_valid drops asynchronously.

Optional Feature:
- Macro: TRNG_HEALTH_EN.
- Defined:
  - A run counter tracks consecutive identical raw_bit values over all sample_valid cycles, including drops.
  - When the run length reaches RCT_LIMIT, health_fail is set and stays set until rst.
  - While health_fail=1, out_valid is forced 0 and no new words complete.
- Undefined: health_fail tied to 0, no run counter logic, and normal packing is unaffected.

Decomposition:
- Shared package trng_pkg holds:
  - the state enum (PAIR_A, PAIR_B, FULL);
  - the pair-decode constants (VN_01, VN_10);
  - the default WIDTH and RCT_LIMIT constants.
- Sub-module rct_monitor holds the run counter, threshold compare and sticky fail; it is instantiated only under TRNG_HEALTH_EN.

Test Plan:
- Reset, then pairs 10,01,10,10,01,01,10,01 -> out_valid=1 one cycle after the last sample, out_data=8'b1011_0010.
- Pairs 00,11,00,10 interleaved with sample_valid=0 gaps -> only one bit accepted, count=1, out_valid=0.
- Complete a word and hold out_ready=0, then drive 5 samples -> out_data is stable and drop_cnt=5. Then assert out_ready together with a sample -> drop_cnt=6, and out_valid=0 the next cycle.
- Drive 300 samples while FULL with DROP_CNT_W=8 -> drop_cnt saturates at 255.
- Assert rst after 3 accepted bits, then 8 fresh pairs -> the word contains only the post-reset bits.
- With TRNG_HEALTH_EN, drive 32 consecutive raw_bit=1 samples -> health_fail=1 after the 32nd and stays 1, and out_valid stays 0. Without the macro, the same stimulus leaves health_fail=0.
